// File: rtl/vram_pixel_shifter_if.sv
// Processor bus snoop inputs, video controls and pixel outputs of the VRAM pixel shifter.
// The master side is the SoC bus and video control; the slave side is the shifter.
interface vram_pixel_shifter_if;
    logic [15:0] memAddr;
    logic        memStrobe;
    logic        memWrite;
    logic [7:0]  memDataRead;
    logic        mode2bpp;
    logic        blank;
    logic        overrunClear;
    logic [1:0]  pixel;
    logic        busy;
    logic        overrun;

    modport master (
        output memAddr, memStrobe, memWrite, memDataRead, mode2bpp, blank, overrunClear,
        input  pixel, busy, overrun
    );

    modport slave (
        input  memAddr, memStrobe, memWrite, memDataRead, mode2bpp, blank, overrunClear,
        output pixel, busy, overrun
    );
endinterface

// File: rtl/vram_pixel_shifter.sv
// Purpose: snoops VRAM reads and serialises each fetched byte into 1bpp/2bpp pixels.
// Latency: hit in cycle N, byte captured in N+1, first pixel shown from N+2.
// Backpressure: none; one held byte absorbs a fetch while busy, further fetches flag overrun.
module vram_pixel_shifter #(
    parameter int DIVIDER  = 2,
    parameter int MATCH_HI = 15,
    parameter int MATCH_LO = 9,
    parameter logic [MATCH_HI-MATCH_LO:0] MATCH_VALUE = 7'h7F,
    parameter bit INVERT   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    vram_pixel_shifter_if.slave bus
);
    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIVIDER - 1);

    logic          hit_d_q,     hit_d_d;
    logic [7:0]    shift_q,     shift_d;
    logic          mode_q,      mode_d;
    logic [3:0]    remaining_q, remaining_d;
    logic [7:0]    hold_q,      hold_d;
    logic          hold_vld_q,  hold_vld_d;
    logic [CW-1:0] div_cnt_q,   div_cnt_d;
    logic          overrun_q,   overrun_d;

    logic       busy;
    logic       tick;
    logic       last;
    logic       ovr_set;
    logic [3:0] reload;
    logic [1:0] pix_raw;
    logic [1:0] inv_mask;
    logic [1:0] pixel_w;

    always_comb begin
        hit_d_d     = bus.memStrobe & ~bus.memWrite &
                      (bus.memAddr[MATCH_HI:MATCH_LO] == MATCH_VALUE);
        shift_d     = shift_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        ovr_set     = 1'b0;

        busy   = (remaining_q != 4'd0);
        tick   = busy && (div_cnt_q == DIV_LAST);
        last   = tick && (remaining_q == 4'd1);
        reload = bus.mode2bpp ? 4'd4 : 4'd8;

        div_cnt_d = (!busy || tick) ? '0 : div_cnt_q + 1'b1;

        if (tick) begin
            if (!last) begin
                shift_d     = mode_q ? {shift_q[5:0], 2'b11} : {shift_q[6:0], 1'b1};
                remaining_d = remaining_q - 4'd1;
            end else if (hold_vld_q) begin
                shift_d     = hold_q;
                mode_d      = bus.mode2bpp;
                remaining_d = reload;
                hold_vld_d  = 1'b0;
            end else begin
                shift_d     = 8'hFF;
                remaining_d = 4'd0;
            end
        end

        // A capture landing exactly as the last pixel ends with an empty hold
        // loads the shifter directly so the hold never outlives the byte stream.
        if (hit_d_q) begin
            if (!busy || (last && !hold_vld_q)) begin
                shift_d     = bus.memDataRead;
                mode_d      = bus.mode2bpp;
                remaining_d = reload;
                div_cnt_d   = '0;
            end else begin
                hold_d     = bus.memDataRead;
                hold_vld_d = 1'b1;
                ovr_set    = hold_vld_q && !last;
            end
        end

        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (bus.overrunClear) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        pix_raw  = mode_q ? shift_q[7:6] : {1'b0, shift_q[7]};
        inv_mask = INVERT ? (mode_q ? 2'b11 : 2'b01) : 2'b00;
        pixel_w  = (bus.blank || !busy) ? 2'b00 : (pix_raw ^ inv_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_d_q     <= 1'b0;
            shift_q     <= 8'hFF;
            mode_q      <= 1'b0;
            remaining_q <= 4'd0;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            div_cnt_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            hit_d_q     <= hit_d_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            div_cnt_q   <= div_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.pixel   = pixel_w;
    assign bus.busy    = busy;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_vram_pixel_shifter.sv
// Bench for vram_pixel_shifter: two instances (divider 2 / no invert, divider 3 / invert)
// share one stimulus stream; a byte-schedule model predicts every output cycle.
module tb_vram_pixel_shifter;
    localparam int NDUT = 2;
    localparam int DIV0 = 2;
    localparam int DIV1 = 3;

    typedef struct {
        int         s;
        int         len;
        logic [7:0] data;
        logic       md;
    } slot_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    vram_pixel_shifter_if bus0();
    vram_pixel_shifter_if bus1();

    assign bus1.memAddr      = bus0.memAddr;
    assign bus1.memStrobe    = bus0.memStrobe;
    assign bus1.memWrite     = bus0.memWrite;
    assign bus1.memDataRead  = bus0.memDataRead;
    assign bus1.mode2bpp     = bus0.mode2bpp;
    assign bus1.blank        = bus0.blank;
    assign bus1.overrunClear = bus0.overrunClear;

    vram_pixel_shifter #(.DIVIDER(DIV0), .INVERT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    vram_pixel_shifter #(.DIVIDER(DIV1), .INVERT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: per instance, the queue of scheduled byte windows [s, s+len).
    slot_t sq[NDUT][$];
    logic  ovr_evt[NDUT][4];
    logic  exp_ovr[NDUT];
    logic       prev_hit = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic int div_of(int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    function automatic logic inv_of(int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    // A byte captured in cycle t starts right after the current stream (or at t+1);
    // a byte still waiting to start after t+1 is overwritten and flags overrun.
    task automatic sched(input int d, input int t, input logic [7:0] data, input logic md);
        slot_t n;
        int    e;
        int    last_i;
        n.len  = (md ? 4 : 8) * div_of(d);
        n.data = data;
        n.md   = md;
        last_i = sq[d].size() - 1;
        if (last_i >= 0 && sq[d][last_i].s > t + 1) begin
            n.s = sq[d][last_i].s;
            sq[d][last_i] = n;
            ovr_evt[d][t % 4] = 1'b1;
        end else begin
            e   = (last_i >= 0) ? sq[d][last_i].s + sq[d][last_i].len : 0;
            n.s = (t + 1 > e) ? t + 1 : e;
            sq[d].push_back(n);
        end
    endtask

    task automatic step(input logic stb, input logic wr, input logic [15:0] addr,
                        input logic [7:0] data, input logic rst_in, input logic blk,
                        input logic clr);
        @(posedge clk);
        #1;
        reset             = rst_in;
        bus0.memDataRead  = prev_hit ? prev_data : 8'($urandom);
        if (prev_hit && !rst_in) begin
            for (int d = 0; d < NDUT; d++) sched(d, cyc, prev_data, bus0.mode2bpp);
        end
        bus0.memStrobe    = stb;
        bus0.memWrite     = wr;
        bus0.memAddr      = addr;
        bus0.blank        = blk;
        bus0.overrunClear = clr;
        prev_hit  = stb && !wr && (addr[15:9] == 7'h7F) && !rst_in;
        prev_data = data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] data);
        step(1'b1, 1'b0, addr, data, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || prev_hit) && n < 400) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL drain: pending windows %0d/%0d after %0d cycles, required 0",
                     sq[0].size(), sq[1].size(), n);
        end
    endtask

    // Monitor: every cycle compare {busy, overrun, pixel} of each instance with the model.
    always @(negedge clk) begin
        logic [3:0] act;
        logic [3:0] expv;
        logic       eb;
        int         v;
        int         k;
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                if (reset) begin
                    sq[d].delete();
                    exp_ovr[d] = 1'b0;
                    for (int j = 0; j < 4; j++) ovr_evt[d][j] = 1'b0;
                end else begin
                    while (sq[d].size() > 0 && sq[d][0].s + sq[d][0].len <= cyc)
                        void'(sq[d].pop_front());
                    eb = 1'b0;
                    v  = 0;
                    if (sq[d].size() > 0 && sq[d][0].s <= cyc) begin
                        eb = 1'b1;
                        k  = (cyc - sq[d][0].s) / div_of(d);
                        if (sq[d][0].md) begin
                            v = (int'(sq[d][0].data) / (4 ** (3 - k))) % 4;
                            if (inv_of(d)) v = 3 - v;
                        end else begin
                            v = (int'(sq[d][0].data) / (2 ** (7 - k))) % 2;
                            if (inv_of(d)) v = 1 - v;
                        end
                        if (bus0.blank) v = 0;
                    end
                    expv = {eb, exp_ovr[d], 2'(v)};
                    act  = (d == 0) ? {bus0.busy, bus0.overrun, bus0.pixel}
                                    : {bus1.busy, bus1.overrun, bus1.pixel};
                    checks++;
                    if (act !== expv) begin
                        errors++;
                        $display("FAIL dut%0d cyc %0d busy/overrun/pixel: got %b required %b",
                                 d, cyc, act, expv);
                    end
                    if (ovr_evt[d][cyc % 4]) begin
                        exp_ovr[d] = 1'b1;
                        ovr_evt[d][cyc % 4] = 1'b0;
                    end else if (bus0.overrunClear) begin
                        exp_ovr[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        int r;
        bus0.memAddr      = 16'h0000;
        bus0.memStrobe    = 1'b0;
        bus0.memWrite     = 1'b0;
        bus0.memDataRead  = 8'h00;
        bus0.mode2bpp     = 1'b0;
        bus0.blank        = 1'b0;
        bus0.overrunClear = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            exp_ovr[d] = 1'b0;
            for (int j = 0; j < 4; j++) ovr_evt[d][j] = 1'b0;
        end
        repeat (3) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
        mon_en = 1'b1;
        idle(3);

        // Single 1bpp byte.
        rd(16'hFE00, 8'h5A);
        idle(30);
        // Two reads 6 cycles apart: seamless hand-over through the hold register.
        rd(16'hFE00, 8'hF0);
        idle(5);
        rd(16'hFE10, 8'h0F);
        drain();
        // Three back-to-back reads: the middle byte is lost, overrun then cleared.
        rd(16'hFE00, 8'hA1);
        rd(16'hFE02, 8'hB2);
        rd(16'hFE04, 8'hC3);
        idle(6);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();
        // 2bpp byte.
        bus0.mode2bpp = 1'b1;
        idle(2);
        rd(16'hFE00, 8'hE4);
        drain();
        bus0.mode2bpp = 1'b0;
        idle(2);
        // Write to a VRAM address and a read outside VRAM: no capture.
        step(1'b1, 1'b1, 16'hFE00, 8'h77, 1'b0, 1'b0, 1'b0);
        rd(16'hE000, 8'h77);
        idle(10);
        // Blanking in the middle of a byte.
        rd(16'hFE00, 8'hC3);
        idle(4);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();
        // Reset mid-byte with the hold register full and overrun set.
        rd(16'hFE00, 8'hA5);
        rd(16'hFE00, 8'h3C);
        rd(16'hFE00, 8'h96);
        idle(4);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(10);

        // Randomised traffic, one phase per pixel mode.
        for (int m = 0; m < 2; m++) begin
            drain();
            bus0.mode2bpp = m[0];
            idle(2);
            for (int i = 0; i < 900; i++) begin
                r = $urandom_range(0, 99);
                if (r < 14) a = {7'h7F, 9'($urandom)};
                else        a = {7'($urandom_range(0, 126)), 9'($urandom)};
                step($urandom_range(0, 99) < 30 || r < 14, ($urandom_range(0, 9) == 0),
                     a, 8'($urandom), ($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
            end
            idle(2);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_pixel_shifter.md
# vram_pixel_shifter

Parametrised video pixel engine that snoops processor VRAM reads on the memory bus and serialises each fetched byte into pixels at a configurable clock divider. It is the successor to the SoC-level inline 1-bit shifter. It adds a holding register for back-to-back fetches without glitching, a 1/2-bit-per-pixel mode, blanking, and overrun detection. It sits beside the memory decoder in the SoC and drives the video pixel output.

## Interface
- DIVIDER, 2: clocks per pixel (≥1); counter width $clog2(DIVIDER), min 1.
- MATCH_HI, 15: top address bit compared for VRAM hit.
- MATCH_LO, 9: bottom address bit compared.
- MATCH_VALUE, 7'h7F: value memAddr[MATCH_HI:MATCH_LO] must equal (width MATCH_HI-MATCH_LO+1).
- INVERT, 1: when 1, emitted pixel bits are inverted (data 1 = dark).

- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- memAddr  in  16  processor bus address.
- memStrobe  in  1  bus access strobe.
- memWrite  in  1  bus write qualifier.
- memDataRead  in  8  read data, valid the cycle after strobe.
- mode2bpp  in  1  0 = 8 px/byte (1 bit), 1 = 4 px/byte (2 bits); sampled at shifter load.
- blank  in  1  forces pixel to 0; does not stall shifting.
- overrunClear  in  1  clears overrun flag.
- pixel  out  2  current pixel; 1bpp drives {1'b0, bit}.
- busy  out  1  shifter holds a byte being emitted.
- overrun  out  1  sticky: a captured byte was lost.

## Operation
- hit = memStrobe & ~memWrite & (memAddr[MATCH_HI:MATCH_LO] == MATCH_VALUE); registered to hitD. Each hit cycle yields one capture of memDataRead in the following (hitD) cycle; consecutive hit cycles yield consecutive captures.
- State: shiftReg[7:0], modeReg, remaining (0..8), holdReg[7:0], holdValid, divCnt, overrun.
- Idle (remaining==0): capture loads shiftReg directly, modeReg<=mode2bpp, remaining<=8 or 4, divCnt<=0, holdValid unchanged (0).
- Busy, capture: holdReg<=data, holdValid<=1; if holdValid was already 1 and hold is not consumed this cycle → overrun<=1 (old hold lost, new kept).
- Pixel tick = busy & divCnt==DIVIDER-1; divCnt wraps to 0 on tick, increments otherwise while busy, held at 0 when idle.
- On tick with remaining>1: shiftReg shifts left by 1 (1bpp) or 2 (2bpp), filling 1s; remaining--.
- On tick with remaining==1: if holdValid → shiftReg<=holdReg, modeReg<=mode2bpp, remaining reload, holdValid<=0 (or new data simultaneously captured goes to hold, holdValid stays 1, no overrun). Else → idle, shiftReg<=8'hFF.
- Simultaneous capture + reload from hold on same cycle is legal and never flags overrun.
- pixel = blank|~busy ? 0 : (modeReg ? shiftReg[7:6] : {0,shiftReg[7]}) XOR (INVERT ? 2'b11/2'b01 : 0); 1bpp inversion affects bit 0 only.
- overrunClear clears overrun; a simultaneous set wins.

## Timing
- Reset: pixel 0, busy 0, overrun 0, holdValid 0, remaining 0, divCnt 0, shiftReg FF, hitD 0.
- Reset mid-byte discards shiftReg and hold immediately; next cycle is idle.
- Latency: hit at cycle N → capture N+1 → pixel registered-valid, busy=1 at N+2. Each pixel lasts exactly DIVIDER cycles; a byte lasts 8·DIVIDER (1bpp) or 4·DIVIDER (2bpp) cycles.
- Hold reload is seamless: no gap cycle between last pixel of one byte and first of the next.
- mode2bpp changes take effect only at the next load.

## Test plan
- Reset, then read 0xFE00 → data 0x5A, DIVIDER=2, INVERT=0, 1bpp: pixel bit0 = 0,1,0,1,1,0,1,0 each 2 cycles starting N+2; busy drops after 16 cycles; pixel 0 after.
- Two reads 6 cycles apart (0xF0 then 0x0F): second byte follows first with zero gap; 16 contiguous pixels, no overrun.
- Three reads back-to-back while busy: overrun=1; overrunClear pulse → 0; third byte emitted second.
- 2bpp, data 0xE4, INVERT=0: pixel = 3,2,1,0; with INVERT=1: 0,1,2,3.
- Write to 0xFE00 and read to 0xE000: no capture, busy stays 0; blank=1 during a byte: pixel 0 but byte still finishes on schedule.
- Reset asserted mid-byte with hold full: next cycle busy=0, pixel=0, overrun=0.
